// File: rtl/riscv_i32_dmem_misaligned_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_i32_dmem_misaligned_sequencer_pkg
// Description : Shared types for the misaligned data-memory sequencer.
//               Holds the size encoding, the FSM state enum, the dmem
//               request/response structs and the read-alignment control
//               struct, plus a helper that turns a size code into a
//               right-justified byte-lane mask.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_i32_dmem_misaligned_sequencer_pkg;

  localparam logic [1:0] c_size_byte = 2'd0;
  localparam logic [1:0] c_size_half = 2'd1;
  localparam logic [1:0] c_size_word = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE1 = 3'd1,
    ST_WAIT1  = 3'd2,
    ST_ISSUE2 = 3'd3,
    ST_WAIT2  = 3'd4
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
    logic        write;
    logic        sequential;
  } dmem_req_t;

  typedef struct packed {
    logic ack;
    logic access_complete;
  } dmem_resp_t;

  typedef struct packed {
    logic [1:0] rotation;
    logic [3:0] byte_clear;
    logic [3:0] byte_enable;
    logic       sign_byte;
    logic       sign_half;
  } rd_ctrl_t;

  // (1<<n)-1 for n = 1/2/4 bytes; the reserved code 3 behaves as a word.
  function automatic logic [3:0] size_len_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      c_size_byte:       m = 4'b0001;
      c_size_half:       m = 4'b0011;
      c_size_word, 2'd3: m = 4'b1111;
      default:           m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_i32_dmem_lane_calc.sv
`default_nettype none
// ============================================================================
// Module      : riscv_i32_dmem_lane_calc
// Description : Combinational byte-lane geometry for one access.
//   addr_lo  in  2 : byte offset within the word
//   size     in  2 : size code (0 byte, 1 half, 2/3 word)
//   mask8    out 8 : lane mask across two words, low nibble = beat 1
//   crossing out 1 : access spills into the next word
//   e1       out 4 : result bytes delivered by beat 1 of a crossing access
//   rotation out 2 : read-data rotation (equals the byte offset)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_i32_dmem_lane_calc
  import riscv_i32_dmem_misaligned_sequencer_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] size,
  output logic [7:0] mask8,
  output logic       crossing,
  output logic [3:0] e1,
  output logic [1:0] rotation
);

  logic [3:0] w_len;

  always_comb begin
    w_len    = size_len_mask(size);
    mask8    = {4'b0000, w_len} << addr_lo;
    crossing = |mask8[7:4];
    // Beat 1 can only supply the bytes from the offset to the top of the word.
    e1       = 4'hF >> addr_lo;
    rotation = addr_lo;
  end

endmodule
`default_nettype wire

// File: rtl/riscv_i32_dmem_misaligned_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : riscv_i32_dmem_misaligned_sequencer
// Description : Splits one load/store at any byte address into one or two
//               word-aligned dmem accesses, with one access outstanding.
//   clk, reset_n            : clock, synchronous active-low reset
//   req_*                   : execute-stage request (valid/ready handshake)
//   dmem_access_req__*      : aligned access request, held until ack
//   dmem_access_resp__*     : ack / access_complete from memory
//   read_stage_data         : merged data from the downstream align stage
//   last_data               : beat-1 merged data of a crossing load
//   read_data_* / sign_*    : per-beat controls for the align stage
//   done, crossed           : final-beat completion pulse and 2-beat flag
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_i32_dmem_misaligned_sequencer
  import riscv_i32_dmem_misaligned_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        dmem_access_req__valid,
  output logic [31:0] dmem_access_req__address,
  output logic [3:0]  dmem_access_req__byte_enable,
  output logic [31:0] dmem_access_req__write_data,
  output logic        dmem_access_req__write,
  output logic        dmem_access_req__sequential,
  input  logic        dmem_access_resp__ack,
  input  logic        dmem_access_resp__access_complete,
  input  logic [31:0] read_stage_data,
  output logic [31:0] last_data,
  output logic [1:0]  read_data_rotation,
  output logic [3:0]  read_data_byte_clear,
  output logic [3:0]  read_data_byte_enable,
  output logic        sign_extend_byte,
  output logic        sign_extend_half,
  output logic        done,
  output logic        crossed
);

  state_t      r_state;
  logic [31:0] r_address;
  logic [31:0] r_write_data;
  logic [31:0] r_last_data;
  logic [1:0]  r_size;
  logic        r_store;
  logic        r_sign;

  logic [7:0]  w_mask8;
  logic        w_crossing;
  logic [3:0]  w_e1;
  logic [1:0]  w_rotation;
  logic [3:0]  w_len;
  logic [31:0] w_rot_wdata;
  logic        w_issue;
  logic        w_beat2;
  logic        w_final;
  logic        w_beat1_done;
  logic        w_beat2_done;
  dmem_resp_t  w_resp;
  dmem_req_t   w_req;
  rd_ctrl_t    w_rd;

  riscv_i32_dmem_lane_calc u_lane_calc (
    .addr_lo  (r_address[1:0]),
    .size     (r_size),
    .mask8    (w_mask8),
    .crossing (w_crossing),
    .e1       (w_e1),
    .rotation (w_rotation)
  );

  always_comb begin
    w_resp.ack             = dmem_access_resp__ack;
    w_resp.access_complete = dmem_access_resp__access_complete;

    w_issue = (r_state == ST_ISSUE1) || (r_state == ST_ISSUE2);
    w_beat2 = (r_state == ST_ISSUE2) || (r_state == ST_WAIT2);
    w_final = !w_crossing || w_beat2;
    w_len   = size_len_mask(r_size);

    // Completion may arrive together with ack, skipping the wait state.
    w_beat1_done = ((r_state == ST_ISSUE1) && w_resp.ack && w_resp.access_complete) ||
                   ((r_state == ST_WAIT1) && w_resp.access_complete);
    w_beat2_done = ((r_state == ST_ISSUE2) && w_resp.ack && w_resp.access_complete) ||
                   ((r_state == ST_WAIT2) && w_resp.access_complete);

    // Store byte i lands in lane (offset + i) mod 4: rotate left by offset bytes.
    case (r_address[1:0])
      2'd0:    w_rot_wdata = r_write_data;
      2'd1:    w_rot_wdata = {r_write_data[23:0], r_write_data[31:24]};
      2'd2:    w_rot_wdata = {r_write_data[15:0], r_write_data[31:16]};
      default: w_rot_wdata = {r_write_data[7:0],  r_write_data[31:8]};
    endcase

    w_req = '0;
    if (w_issue) begin
      w_req.valid       = 1'b1;
      w_req.address     = {r_address[31:2], 2'b00} + (w_beat2 ? 32'd4 : 32'd0);
      w_req.byte_enable = w_beat2 ? w_mask8[7:4] : w_mask8[3:0];
      w_req.write_data  = w_rot_wdata;
      w_req.write       = r_store;
      w_req.sequential  = w_beat2;
    end

    w_rd = '0;
    if (r_state != ST_IDLE) begin
      w_rd.rotation = w_rotation;
      if (!w_crossing) begin
        w_rd.byte_enable = w_len;
        w_rd.byte_clear  = 4'hF;
      end else if (!w_beat2) begin
        w_rd.byte_enable = w_e1;
        w_rd.byte_clear  = 4'hF;
      end else begin
        // Second beat fills only the upper result bytes and keeps beat-1 bytes.
        w_rd.byte_enable = w_len & ~w_e1;
        w_rd.byte_clear  = ~w_e1;
      end
      w_rd.sign_byte = r_sign && (r_size == c_size_byte) && w_final;
      w_rd.sign_half = r_sign && (r_size == c_size_half) && w_final;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_address    <= '0;
      r_write_data <= '0;
      r_last_data  <= '0;
      r_size       <= '0;
      r_store      <= 1'b0;
      r_sign       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_address    <= req_address;
            r_write_data <= req_write_data;
            r_size       <= req_size;
            r_store      <= req_store;
            r_sign       <= req_sign;
            r_state      <= ST_ISSUE1;
          end
        end
        ST_ISSUE1: begin
          if (w_resp.ack) begin
            if (w_resp.access_complete) r_state <= w_crossing ? ST_ISSUE2 : ST_IDLE;
            else                        r_state <= ST_WAIT1;
          end
        end
        ST_WAIT1: begin
          if (w_resp.access_complete) r_state <= w_crossing ? ST_ISSUE2 : ST_IDLE;
        end
        ST_ISSUE2: begin
          if (w_resp.ack) r_state <= w_resp.access_complete ? ST_IDLE : ST_WAIT2;
        end
        ST_WAIT2: begin
          if (w_resp.access_complete) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_beat1_done && w_crossing && !r_store) r_last_data <= read_stage_data;
    end
  end

  assign req_ready                    = reset_n && (r_state == ST_IDLE);
  assign done                         = reset_n && ((w_beat1_done && !w_crossing) || w_beat2_done);
  assign crossed                      = reset_n && w_beat2_done;
  assign last_data                    = r_last_data;

  assign dmem_access_req__valid       = w_req.valid;
  assign dmem_access_req__address     = w_req.address;
  assign dmem_access_req__byte_enable = w_req.byte_enable;
  assign dmem_access_req__write_data  = w_req.write_data;
  assign dmem_access_req__write       = w_req.write;
  assign dmem_access_req__sequential  = w_req.sequential;

  assign read_data_rotation           = w_rd.rotation;
  assign read_data_byte_clear         = w_rd.byte_clear;
  assign read_data_byte_enable        = w_rd.byte_enable;
  assign sign_extend_byte             = w_rd.sign_byte;
  assign sign_extend_half             = w_rd.sign_half;

endmodule
`default_nettype wire

// File: tb/tb_riscv_i32_dmem_misaligned_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_i32_dmem_misaligned_sequencer
// Description : Directed self-checking bench for the misaligned dmem
//               sequencer; expected values are hand-computed constants.
// Revision    : 1.1 - inline checks
// ============================================================================
module tb_riscv_i32_dmem_misaligned_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        valid;
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
    logic        write;
    logic        sequential;
    logic        ack;
    logic        complete;
    logic [31:0] read_stage_data;
    logic [31:0] last_data;
    logic [1:0]  rotation;
    logic [3:0]  rd_clear;
    logic [3:0]  rd_enable;
    logic        sx_byte;
    logic        sx_half;
    logic        done;
    logic        crossed;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    riscv_i32_dmem_misaligned_sequencer dut (
        .clk                               (clk),
        .reset_n                           (reset_n),
        .req_valid                         (req_valid),
        .req_ready                         (req_ready),
        .req_store                         (req_store),
        .req_size                          (req_size),
        .req_sign                          (req_sign),
        .req_address                       (req_address),
        .req_write_data                    (req_write_data),
        .dmem_access_req__valid            (valid),
        .dmem_access_req__address          (address),
        .dmem_access_req__byte_enable      (byte_enable),
        .dmem_access_req__write_data       (write_data),
        .dmem_access_req__write            (write),
        .dmem_access_req__sequential       (sequential),
        .dmem_access_resp__ack             (ack),
        .dmem_access_resp__access_complete (complete),
        .read_stage_data                   (read_stage_data),
        .last_data                         (last_data),
        .read_data_rotation                (rotation),
        .read_data_byte_clear              (rd_clear),
        .read_data_byte_enable             (rd_enable),
        .sign_extend_byte                  (sx_byte),
        .sign_extend_half                  (sx_half),
        .done                              (done),
        .crossed                           (crossed)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd);
        step();
        req_valid = 1'b1; req_store = st; req_size = sz; req_sign = sg;
        req_address = addr; req_write_data = wd;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL accept_ready observed=0x%0h expected=0x1", req_ready); end
        step();
        req_valid = 1'b0;
    endtask

    task automatic resp(input logic a, input logic c, input logic [31:0] d);
        ack = a; complete = c; read_stage_data = d;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
        req_sign = 1'b0; req_address = '0; req_write_data = '0;
        ack = 1'b0; complete = 1'b0; read_stage_data = '0;

        step(); step(); #1;
        n_vec++; if (req_ready !== 1'b0) begin n_mis++; $display("FAIL rst_ready observed=0x%0h expected=0x0", req_ready); end
        n_vec++; if (valid !== 1'b0) begin n_mis++; $display("FAIL rst_valid observed=0x%0h expected=0x0", valid); end
        n_vec++; if (address !== 32'h0) begin n_mis++; $display("FAIL rst_addr observed=0x%0h expected=0x0", address); end
        n_vec++; if (byte_enable !== 4'h0) begin n_mis++; $display("FAIL rst_be observed=0x%0h expected=0x0", byte_enable); end
        n_vec++; if (done !== 1'b0) begin n_mis++; $display("FAIL rst_done observed=0x%0h expected=0x0", done); end
        n_vec++; if (last_data !== 32'h0) begin n_mis++; $display("FAIL rst_last observed=0x%0h expected=0x0", last_data); end
        step(); reset_n = 1'b1;

        accept(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0);
        resp(1'b1, 1'b1, 32'h0BAD_F00D);
        n_vec++; if (valid !== 1'b1) begin n_mis++; $display("FAIL w_valid observed=0x%0h expected=0x1", valid); end
        n_vec++; if (address !== 32'h0000_1000) begin n_mis++; $display("FAIL w_addr observed=0x%0h expected=0x1000", address); end
        n_vec++; if (byte_enable !== 4'hF) begin n_mis++; $display("FAIL w_be observed=0x%0h expected=0xf", byte_enable); end
        n_vec++; if (rotation !== 2'd0) begin n_mis++; $display("FAIL w_rot observed=0x%0h expected=0x0", rotation); end
        n_vec++; if (rd_enable !== 4'hF) begin n_mis++; $display("FAIL w_en observed=0x%0h expected=0xf", rd_enable); end
        n_vec++; if (rd_clear !== 4'hF) begin n_mis++; $display("FAIL w_clr observed=0x%0h expected=0xf", rd_clear); end
        n_vec++; if (done !== 1'b1) begin n_mis++; $display("FAIL w_done observed=0x%0h expected=0x1", done); end
        n_vec++; if (crossed !== 1'b0) begin n_mis++; $display("FAIL w_crossed observed=0x%0h expected=0x0", crossed); end
        step(); resp(1'b0, 1'b0, 32'h0);
        n_vec++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL w_idle_ready observed=0x%0h expected=0x1", req_ready); end
        n_vec++; if (done !== 1'b0) begin n_mis++; $display("FAIL w_idle_done observed=0x%0h expected=0x0", done); end

        accept(1'b0, 2'd1, 1'b0, 32'h0000_1003, 32'h0);
        resp(1'b1, 1'b1, 32'h1122_3344);
        n_vec++; if (address !== 32'h0000_1000) begin n_mis++; $display("FAIL h_b1_addr observed=0x%0h expected=0x1000", address); end
        n_vec++; if (byte_enable !== 4'b1000) begin n_mis++; $display("FAIL h_b1_be observed=0x%0h expected=0x8", byte_enable); end
        n_vec++; if (sequential !== 1'b0) begin n_mis++; $display("FAIL h_b1_seq observed=0x%0h expected=0x0", sequential); end
        n_vec++; if (rd_enable !== 4'b0001) begin n_mis++; $display("FAIL h_b1_en observed=0x%0h expected=0x1", rd_enable); end
        n_vec++; if (rd_clear !== 4'b1111) begin n_mis++; $display("FAIL h_b1_clr observed=0x%0h expected=0xf", rd_clear); end
        n_vec++; if (rotation !== 2'd3) begin n_mis++; $display("FAIL h_b1_rot observed=0x%0h expected=0x3", rotation); end
        n_vec++; if (done !== 1'b0) begin n_mis++; $display("FAIL h_b1_done observed=0x%0h expected=0x0", done); end
        step(); resp(1'b1, 1'b1, 32'h5555_AAAA);
        n_vec++; if (address !== 32'h0000_1004) begin n_mis++; $display("FAIL h_b2_addr observed=0x%0h expected=0x1004", address); end
        n_vec++; if (byte_enable !== 4'b0001) begin n_mis++; $display("FAIL h_b2_be observed=0x%0h expected=0x1", byte_enable); end
        n_vec++; if (sequential !== 1'b1) begin n_mis++; $display("FAIL h_b2_seq observed=0x%0h expected=0x1", sequential); end
        n_vec++; if (rd_enable !== 4'b0010) begin n_mis++; $display("FAIL h_b2_en observed=0x%0h expected=0x2", rd_enable); end
        n_vec++; if (rd_clear !== 4'b1110) begin n_mis++; $display("FAIL h_b2_clr observed=0x%0h expected=0xe", rd_clear); end
        n_vec++; if (rotation !== 2'd3) begin n_mis++; $display("FAIL h_b2_rot observed=0x%0h expected=0x3", rotation); end
        n_vec++; if (last_data !== 32'h1122_3344) begin n_mis++; $display("FAIL h_b2_last observed=0x%0h expected=0x11223344", last_data); end
        n_vec++; if (done !== 1'b1) begin n_mis++; $display("FAIL h_b2_done observed=0x%0h expected=0x1", done); end
        n_vec++; if (crossed !== 1'b1) begin n_mis++; $display("FAIL h_b2_crossed observed=0x%0h expected=0x1", crossed); end
        step(); resp(1'b0, 1'b0, 32'h0);

        accept(1'b1, 2'd2, 1'b0, 32'h0000_2002, 32'hAABB_CCDD);
        resp(1'b1, 1'b1, 32'h0);
        n_vec++; if (address !== 32'h0000_2000) begin n_mis++; $display("FAIL s_b1_addr observed=0x%0h expected=0x2000", address); end
        n_vec++; if (byte_enable !== 4'b1100) begin n_mis++; $display("FAIL s_b1_be observed=0x%0h expected=0xc", byte_enable); end
        n_vec++; if (write_data !== 32'hCCDD_AABB) begin n_mis++; $display("FAIL s_b1_wd observed=0x%0h expected=0xccddaabb", write_data); end
        n_vec++; if (write !== 1'b1) begin n_mis++; $display("FAIL s_b1_wr observed=0x%0h expected=0x1", write); end
        n_vec++; if (done !== 1'b0) begin n_mis++; $display("FAIL s_b1_done observed=0x%0h expected=0x0", done); end
        step(); resp(1'b1, 1'b1, 32'h0);
        n_vec++; if (address !== 32'h0000_2004) begin n_mis++; $display("FAIL s_b2_addr observed=0x%0h expected=0x2004", address); end
        n_vec++; if (byte_enable !== 4'b0011) begin n_mis++; $display("FAIL s_b2_be observed=0x%0h expected=0x3", byte_enable); end
        n_vec++; if (write_data !== 32'hCCDD_AABB) begin n_mis++; $display("FAIL s_b2_wd observed=0x%0h expected=0xccddaabb", write_data); end
        n_vec++; if (sequential !== 1'b1) begin n_mis++; $display("FAIL s_b2_seq observed=0x%0h expected=0x1", sequential); end
        n_vec++; if (done !== 1'b1) begin n_mis++; $display("FAIL s_b2_done observed=0x%0h expected=0x1", done); end
        n_vec++; if (crossed !== 1'b1) begin n_mis++; $display("FAIL s_b2_crossed observed=0x%0h expected=0x1", crossed); end
        n_vec++; if (last_data !== 32'h1122_3344) begin n_mis++; $display("FAIL s_last_held observed=0x%0h expected=0x11223344", last_data); end
        step(); resp(1'b0, 1'b0, 32'h0);

        accept(1'b0, 2'd0, 1'b1, 32'h0000_3001, 32'h0);
        resp(1'b1, 1'b1, 32'h0);
        n_vec++; if (byte_enable !== 4'b0010) begin n_mis++; $display("FAIL sb_be observed=0x%0h expected=0x2", byte_enable); end
        n_vec++; if (rotation !== 2'd1) begin n_mis++; $display("FAIL sb_rot observed=0x%0h expected=0x1", rotation); end
        n_vec++; if (rd_enable !== 4'b0001) begin n_mis++; $display("FAIL sb_en observed=0x%0h expected=0x1", rd_enable); end
        n_vec++; if (sx_byte !== 1'b1) begin n_mis++; $display("FAIL sb_sx observed=0x%0h expected=0x1", sx_byte); end
        n_vec++; if (done !== 1'b1) begin n_mis++; $display("FAIL sb_done observed=0x%0h expected=0x1", done); end
        step(); resp(1'b0, 1'b0, 32'h0);

        accept(1'b0, 2'd1, 1'b1, 32'h0000_3003, 32'h0);
        resp(1'b1, 1'b1, 32'h0000_0080);
        n_vec++; if (sx_half !== 1'b0) begin n_mis++; $display("FAIL sh_b1_sx observed=0x%0h expected=0x0", sx_half); end
        n_vec++; if (done !== 1'b0) begin n_mis++; $display("FAIL sh_b1_done observed=0x%0h expected=0x0", done); end
        step(); resp(1'b1, 1'b1, 32'h0);
        n_vec++; if (sx_half !== 1'b1) begin n_mis++; $display("FAIL sh_b2_sx observed=0x%0h expected=0x1", sx_half); end
        n_vec++; if (sx_byte !== 1'b0) begin n_mis++; $display("FAIL sh_b2_sxb observed=0x%0h expected=0x0", sx_byte); end
        n_vec++; if (done !== 1'b1) begin n_mis++; $display("FAIL sh_b2_done observed=0x%0h expected=0x1", done); end
        n_vec++; if (last_data !== 32'h0000_0080) begin n_mis++; $display("FAIL sh_last observed=0x%0h expected=0x80", last_data); end
        step(); resp(1'b0, 1'b0, 32'h0);

        accept(1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) step();
            resp(1'b0, 1'b0, 32'h0);
            n_vec++; if (valid !== 1'b1) begin n_mis++; $display("FAIL dl_hold_valid observed=0x%0h expected=0x1", valid); end
            n_vec++; if (address !== 32'h0000_4000) begin n_mis++; $display("FAIL dl_hold_addr observed=0x%0h expected=0x4000", address); end
            n_vec++; if (byte_enable !== 4'b1100) begin n_mis++; $display("FAIL dl_hold_be observed=0x%0h expected=0xc", byte_enable); end
            n_vec++; if (done !== 1'b0) begin n_mis++; $display("FAIL dl_hold_done observed=0x%0h expected=0x0", done); end
        end
        step(); resp(1'b1, 1'b0, 32'h0);
        n_vec++; if (valid !== 1'b1) begin n_mis++; $display("FAIL dl_ack_valid observed=0x%0h expected=0x1", valid); end
        n_vec++; if (address !== 32'h0000_4000) begin n_mis++; $display("FAIL dl_ack_addr observed=0x%0h expected=0x4000", address); end
        n_vec++; if (done !== 1'b0) begin n_mis++; $display("FAIL dl_ack_done observed=0x%0h expected=0x0", done); end
        step(); resp(1'b0, 1'b0, 32'h0);
        n_vec++; if (valid !== 1'b0) begin n_mis++; $display("FAIL dl_wait1_valid observed=0x%0h expected=0x0", valid); end
        n_vec++; if (done !== 1'b0) begin n_mis++; $display("FAIL dl_wait1_done observed=0x%0h expected=0x0", done); end
        step(); resp(1'b0, 1'b1, 32'hDEAD_BEEF);
        n_vec++; if (done !== 1'b0) begin n_mis++; $display("FAIL dl_c1_done observed=0x%0h expected=0x0", done); end
        n_vec++; if (rd_enable !== 4'b0011) begin n_mis++; $display("FAIL dl_c1_en observed=0x%0h expected=0x3", rd_enable); end
        n_vec++; if (rd_clear !== 4'hF) begin n_mis++; $display("FAIL dl_c1_clr observed=0x%0h expected=0xf", rd_clear); end
        n_vec++; if (rotation !== 2'd2) begin n_mis++; $display("FAIL dl_c1_rot observed=0x%0h expected=0x2", rotation); end
        step(); resp(1'b1, 1'b0, 32'h0);
        n_vec++; if (last_data !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL dl_b2_last observed=0x%0h expected=0xdeadbeef", last_data); end
        n_vec++; if (valid !== 1'b1) begin n_mis++; $display("FAIL dl_b2_valid observed=0x%0h expected=0x1", valid); end
        n_vec++; if (address !== 32'h0000_4004) begin n_mis++; $display("FAIL dl_b2_addr observed=0x%0h expected=0x4004", address); end
        n_vec++; if (byte_enable !== 4'b0011) begin n_mis++; $display("FAIL dl_b2_be observed=0x%0h expected=0x3", byte_enable); end
        n_vec++; if (sequential !== 1'b1) begin n_mis++; $display("FAIL dl_b2_seq observed=0x%0h expected=0x1", sequential); end
        n_vec++; if (done !== 1'b0) begin n_mis++; $display("FAIL dl_b2_done observed=0x%0h expected=0x0", done); end
        step(); resp(1'b0, 1'b0, 32'h0);
        n_vec++; if (valid !== 1'b0) begin n_mis++; $display("FAIL dl_wait2_valid observed=0x%0h expected=0x0", valid); end
        n_vec++; if (done !== 1'b0) begin n_mis++; $display("FAIL dl_wait2_done observed=0x%0h expected=0x0", done); end
        step(); resp(1'b0, 1'b1, 32'h0);
        n_vec++; if (done !== 1'b1) begin n_mis++; $display("FAIL dl_c2_done observed=0x%0h expected=0x1", done); end
        n_vec++; if (crossed !== 1'b1) begin n_mis++; $display("FAIL dl_c2_crossed observed=0x%0h expected=0x1", crossed); end
        n_vec++; if (rd_enable !== 4'b1100) begin n_mis++; $display("FAIL dl_c2_en observed=0x%0h expected=0xc", rd_enable); end
        n_vec++; if (rd_clear !== 4'b1100) begin n_mis++; $display("FAIL dl_c2_clr observed=0x%0h expected=0xc", rd_clear); end
        step(); resp(1'b0, 1'b0, 32'h0);

        accept(1'b0, 2'd1, 1'b0, 32'h0000_5003, 32'h0);
        resp(1'b1, 1'b1, 32'h5566_7788);
        step(); resp(1'b1, 1'b0, 32'h0);
        n_vec++; if (last_data !== 32'h5566_7788) begin n_mis++; $display("FAIL rw_last observed=0x%0h expected=0x55667788", last_data); end
        step(); resp(1'b0, 1'b0, 32'h0);
        reset_n = 1'b0; #1;
        n_vec++; if (req_ready !== 1'b0) begin n_mis++; $display("FAIL rw_ready_in_rst observed=0x%0h expected=0x0", req_ready); end
        step(); reset_n = 1'b1; resp(1'b0, 1'b1, 32'hFFFF_FFFF);
        n_vec++; if (done !== 1'b0) begin n_mis++; $display("FAIL rw_stray_done observed=0x%0h expected=0x0", done); end
        n_vec++; if (crossed !== 1'b0) begin n_mis++; $display("FAIL rw_stray_crossed observed=0x%0h expected=0x0", crossed); end
        n_vec++; if (last_data !== 32'h0) begin n_mis++; $display("FAIL rw_last_clr observed=0x%0h expected=0x0", last_data); end
        n_vec++; if (valid !== 1'b0) begin n_mis++; $display("FAIL rw_valid observed=0x%0h expected=0x0", valid); end
        n_vec++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL rw_ready observed=0x%0h expected=0x1", req_ready); end
        step(); resp(1'b0, 1'b0, 32'h0);

        accept(1'b0, 2'd0, 1'b0, 32'h0000_6000, 32'h0);
        resp(1'b1, 1'b1, 32'h0);
        n_vec++; if (address !== 32'h0000_6000) begin n_mis++; $display("FAIL pr_addr observed=0x%0h expected=0x6000", address); end
        n_vec++; if (byte_enable !== 4'b0001) begin n_mis++; $display("FAIL pr_be observed=0x%0h expected=0x1", byte_enable); end
        n_vec++; if (done !== 1'b1) begin n_mis++; $display("FAIL pr_done observed=0x%0h expected=0x1", done); end
        n_vec++; if (crossed !== 1'b0) begin n_mis++; $display("FAIL pr_crossed observed=0x%0h expected=0x0", crossed); end
        step(); resp(1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_i32_dmem_misaligned_sequencer.md
# riscv_i32_dmem_misaligned_sequencer

Sequencer that converts one execute-stage load or store, at any byte address, into one or two word-aligned data-memory accesses. It drives the dmem access request and the per-beat read-alignment controls consumed by the downstream read-data alignment stage. It captures the first beat's merged data into `last_data`, so a load that crosses a word boundary is assembled over two accesses. Only one access is ever outstanding.

## Interface
Parameters: none.
- `clk` in 1 — single clock, all state on rising edge
- `reset_n` in 1 — synchronous, active-low reset
- `req_valid` in 1 — execute stage presents an access
- `req_ready` out 1 — block idle; request accepted when `req_valid && req_ready`
- `req_store` in 1 — 1 = store, 0 = load
- `req_size` in 2 — 0 byte, 1 half, 2 word; 3 treated as word
- `req_sign` in 1 — sign-extend load result (byte/half only)
- `req_address` in 32 — byte address
- `req_write_data` in 32 — store data, right-justified
- `dmem_access_req__valid` out 1 — access request
- `dmem_access_req__address` out 32 — word-aligned, bits [1:0] = 0
- `dmem_access_req__byte_enable` out 4 — lane enables
- `dmem_access_req__write_data` out 32 — lane-rotated store data
- `dmem_access_req__write` out 1 — store beat
- `dmem_access_req__sequential` out 1 — high on second beat only
- `dmem_access_resp__ack` in 1 — request accepted this cycle
- `dmem_access_resp__access_complete` in 1 — data/response valid this cycle
- `read_stage_data` in 32 — merged output of downstream alignment stage
- `last_data` out 32 — registered first-beat merged data
- `read_data_rotation` out 2; `read_data_byte_clear` out 4; `read_data_byte_enable` out 4; `sign_extend_byte` out 1; `sign_extend_half` out 1 — per-beat alignment controls
- `done` out 1 — final beat complete (one-cycle pulse)
- `crossed` out 1 — qualifies `done`: access used two beats

## Operation
- Definitions:
  - a = `address[1:0]`; n = 1/2/4 bytes.
  - mask8 = ((1<<n)-1) << a.
  - Access crosses a word boundary when a+n > 4.
- Beat 1:
  - address = `req_address & ~3`
  - byte_enable = mask8[3:0]
- Beat 2 (crossing only):
  - address = (`req_address & ~3`) + 4, wraps modulo 2^32
  - byte_enable = mask8[7:4]
  - sequential = 1
- Write data: byte i of `req_write_data` goes to lane (a+i) mod 4, identical on both beats.
- Read controls:
  - rotation = a on both beats.
  - Non-crossing: enable = (1<<n)-1, clear = 4'hF.
  - Crossing beat 1: enable e1 = ((1<<(4-a))-1), clear = 4'hF.
  - Crossing beat 2: enable = ((1<<n)-1) & ~e1, clear = ~e1.
- Sign extension:
  - `sign_extend_byte` = `req_sign` && size byte, asserted on the final beat only; 0 on beat 1 of a crossing load.
  - `sign_extend_half` follows the same rule for size half.
- `last_data` loads `read_stage_data` on the beat-1 `access_complete` of a crossing load. Otherwise it holds.
- Stores use the same beats; read controls are don't-care but driven as above.

## Timing
- FSM states: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2.
- IDLE:
  - `req_ready` = 1.
  - Accept → ISSUE1 next cycle; request fields are registered.
- ISSUE1/ISSUE2:
  - `valid` = 1 and is held, with all request fields stable, until `ack`.
  - `ack` without `access_complete` → WAITx.
  - `ack` with `access_complete` → skip WAITx.
- WAITx: `valid` = 0; wait for `access_complete`.
- Beat-1 complete:
  - Crossing → ISSUE2 next cycle.
  - Non-crossing → `done` = 1 that cycle, next state IDLE.
- Beat-2 complete: `done` = 1, `crossed` = 1 that cycle, next state IDLE.
- Read controls are combinational from registered state and valid in every `access_complete` cycle.
- Minimum latency, accept → `done`: 1 cycle for aligned, 2 cycles for crossing (ack+complete same cycle). Back-to-back: the next accept is the cycle after `done`.
- Reset values:
  - state IDLE, `last_data` 0.
  - All access outputs 0, `done` 0, `crossed` 0.
  - `req_ready` is 0 while `reset_n` = 0.
- Reset mid-access: the access is abandoned and IDLE is entered at that edge. Any response arriving later is ignored.
- `access_complete` in IDLE is ignored.

## Structure
- Shared package:
  - size encoding constants
  - FSM state enum
  - dmem access request/response structs
  - read-control struct (rotation, clear, enable, sign flags)
- One combinational sub-module, `riscv_i32_dmem_lane_calc`: (address[1:0], size) → mask8, crossing flag, e1, rotation.

## Test plan
- Aligned word load at 0x1000:
  - Expected: one beat, BE 4'hF, rotation 0, enable F, clear F.
  - `done` with `crossed` = 0 in the complete cycle.
- Halfword load at 0x1003:
  - Beat 1: 0x1000, BE 4'b1000, enable 0001, clear 1111.
  - Beat 2: 0x1004, BE 0001, sequential 1, enable 0010, clear 1110.
  - Expected: rotation 3 on both beats; `last_data` = beat-1 `read_stage_data`.
- Word store 0xAABBCCDD at 0x2002:
  - Expected: write data 0xCCDDAABB on both beats.
  - Beat 1: 0x2000, BE 1100. Beat 2: 0x2004, BE 0011.
- Signed byte load at 0x3001:
  - Expected: single beat, BE 0010, rotation 1, `sign_extend_byte` = 1.
  - Signed half crossing at 0x3003: `sign_extend_half` = 0 on beat 1, 1 on beat 2.
- Ack delayed 3 cycles, complete 2 cycles after ack:
  - Expected: `valid` and fields held stable; `valid` low in WAIT; `done` only on the final complete.
- `reset_n` low during WAIT2:
  - Expected: IDLE next edge, `last_data` 0, a stray `access_complete` gives no `done`.
  - Next request processes normally.
